// File: rtl/cutoff_freq_tracker_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : cutoff_pkg                                                  |
// | Purpose  : Shared types and constants for the cutoff-frequency tracker |
// |            (FSM state encoding, response-mode encoding, Q1.16 unity,   |
// |            divider iteration count).                                   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package cutoff_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_MAP  = 3'd2,
    S_CALC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef enum logic {
    MODE_LINEAR = 1'b0,
    MODE_QUAD   = 1'b1
  } mode_e;

  // 1.0 in Q1.16
  localparam int Q16_ONE    = 65536;
  // Quotient bits produced by the iterative divider, one per cycle
  localparam int DIV_CYCLES = 16;

endpackage
`default_nettype wire

// File: rtl/cutoff_freq_tracker_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : cutoff_freq_tracker_if                                     |
// | Purpose   : Request/result bundle of the cutoff-frequency tracker.     |
// | Ports     : in_valid/in_ready handshake with in_ch, env_avg,           |
// |             filter_strength_ratio, mode; result strobe out_valid with  |
// |             out_ch, out_freq (Q8.16).                                  |
// |             master = requester side, slave = tracker side.             |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
interface cutoff_freq_tracker_if #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int CH_W         = 1
);
  logic                    in_valid;
  logic                    in_ready;
  logic [CH_W-1:0]         in_ch;
  logic [SAMPLE_WIDTH-1:0] env_avg;
  logic [3:0]              filter_strength_ratio;
  logic                    mode;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic [SAMPLE_WIDTH-1:0] out_freq;

  modport master (
    output in_valid, in_ch, env_avg, filter_strength_ratio, mode,
    input  in_ready, out_valid, out_ch, out_freq
  );

  modport slave (
    input  in_valid, in_ch, env_avg, filter_strength_ratio, mode,
    output in_ready, out_valid, out_ch, out_freq
  );
endinterface
`default_nettype wire

// File: rtl/cutoff_freq_tracker_divider.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : cutoff_seq_divider                                          |
// | Purpose  : Start/done restoring unsigned divider. Computes             |
// |            floor(dividend * 2^QBITS / divisor), one quotient bit per   |
// |            cycle, exactly QBITS cycles after start.                    |
// | Ports    : clk, rst_n (async, active-low)                              |
// |            start_i    - load operands (one-cycle pulse)                |
// |            dividend_i - initial remainder, must be < divisor for a     |
// |                         meaningful quotient                            |
// |            divisor_i  - divisor                                        |
// |            done_o     - high during the final iteration cycle;         |
// |                         quotient_o is complete from the next cycle     |
// |            quotient_o - QBITS-bit quotient                             |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module cutoff_seq_divider #(
  parameter int WIDTH = 24,
  parameter int QBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [QBITS-1:0] quotient_o
);

  localparam int CNT_W = $clog2(QBITS);

  logic [WIDTH-1:0] rem_q;
  logic [QBITS-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH:0]   w_next;
  logic             w_unused_msb;

  // Shift in a zero bit and try to subtract the divisor.
  assign w_shift = {rem_q, 1'b0};
  assign w_ge    = (w_shift >= {1'b0, divisor_i});
  assign w_next  = w_ge ? (w_shift - {1'b0, divisor_i}) : w_shift;
  // While remainder < divisor the restored remainder always fits WIDTH bits;
  // the top bit only carries meaning for out-of-range dividends whose
  // quotient the caller discards.
  assign w_unused_msb = w_next[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= dividend_i;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= w_next[WIDTH-1:0];
      quo_q <= {quo_q[QBITS-2:0], w_ge};
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(QBITS - 1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_o     = busy_q && (cnt_q == CNT_W'(QBITS - 1));
  assign quotient_o = quo_q;

endmodule
`default_nettype wire

// File: rtl/cutoff_freq_tracker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : cutoff_freq_tracker                                         |
// | Purpose  : Multi-channel sequential mapper from envelope average to    |
// |            digital filter cutoff (Q8.16), clamped to                   |
// |            [FC_MIN_DIGITAL, FC_MAX_DIGITAL], linear or quadratic       |
// |            response, iterative divider. One request in flight; result  |
// |            strobe 19 cycles after acceptance.                          |
// | Ports    : clk, rst_n (async, active-low)                              |
// |            bus (slave) - in_valid/in_ready/in_ch/env_avg/              |
// |                          filter_strength_ratio/mode and                |
// |                          out_valid/out_ch/out_freq                     |
// | Options  : CUTOFF_SLEW_EN - per-channel slew limiting of the cutoff    |
// |                             by SLEW_STEP per update.                   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module cutoff_freq_tracker
  import cutoff_pkg::*;
#(
  parameter int                      SAMPLE_WIDTH   = 24,
  parameter int                      NUM_CH         = 2,
  parameter logic [SAMPLE_WIDTH-1:0] FC_MIN_DIGITAL = 24'h00035a,
  parameter logic [SAMPLE_WIDTH-1:0] FC_MAX_DIGITAL = 24'h014f1a,
  parameter int                      TYPICAL_ENV    = 1_000_000,
  parameter logic [SAMPLE_WIDTH-1:0] SLEW_STEP      = 24'h000400
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cutoff_freq_tracker_if.slave  bus
);

  localparam int                      CH_W     = $clog2(NUM_CH);
  localparam int                      PROD_W   = 17 + SAMPLE_WIDTH;
  localparam logic [SAMPLE_WIDTH-1:0] C_TYP    = SAMPLE_WIDTH'(TYPICAL_ENV);
  localparam logic [SAMPLE_WIDTH-1:0] FC_RANGE = FC_MAX_DIGITAL - FC_MIN_DIGITAL;

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q;
  logic                    sat_q;
  logic [3:0]              strength_q;
  mode_e                   mode_q;
  logic [16:0]             mapped_q;
  logic [CH_W-1:0]         out_ch_q;
  logic [SAMPLE_WIDTH-1:0] out_freq_q;

  logic                    w_accept;
  logic                    w_div_done;
  logic [15:0]             w_quot;
  logic [16:0]             w_scaled;
  logic [33:0]             w_sq;
  logic [17:0]             w_sq_shr;
  logic [16:0]             w_mapped_d;
  logic [21:0]             w_ctl_full;
  logic [17:0]             w_ctl_shr;
  logic [16:0]             w_ctl;
  logic [PROD_W-1:0]       w_prod;
  logic [SAMPLE_WIDTH:0]   w_off;
  logic [SAMPLE_WIDTH+1:0] w_sum;
  logic [SAMPLE_WIDTH-1:0] w_target;
  logic [SAMPLE_WIDTH-1:0] w_freq;
  logic                    w_ch_ok;

  assign w_accept = bus.in_valid && (state_q == S_IDLE);

  // ---------------------------------------------------------------------
  // Divider: env_avg / TYPICAL_ENV in Q0.16. Saturated requests still run
  // the full 16 cycles so latency never depends on the data.
  // ---------------------------------------------------------------------
  cutoff_seq_divider #(
    .WIDTH (SAMPLE_WIDTH),
    .QBITS (DIV_CYCLES)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (w_accept),
    .dividend_i (bus.env_avg),
    .divisor_i  (C_TYP),
    .done_o     (w_div_done),
    .quotient_o (w_quot)
  );

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept)   state_d = S_DIV;
      S_DIV:   if (w_div_done) state_d = S_MAP;
      S_MAP:   state_d = S_CALC;
      S_CALC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  assign w_scaled = sat_q ? 17'(Q16_ONE) : {1'b0, w_quot};

  // Quadratic response: (x^2) >> 16 stays within [0, 1.0] for x <= 1.0.
  assign w_sq       = 34'(w_scaled) * 34'(w_scaled);
  assign w_sq_shr   = 18'(w_sq >> 16);
  assign w_mapped_d = (mode_q == MODE_QUAD)
                    ? ((w_sq_shr > 18'(Q16_ONE)) ? 17'(Q16_ONE) : w_sq_shr[16:0])
                    : w_scaled;

  // Strength scaling by (strength+1)/16, then projection onto the range.
  assign w_ctl_full = 22'(mapped_q) * 22'(5'(strength_q) + 5'd1);
  assign w_ctl_shr  = 18'(w_ctl_full >> 4);
  assign w_ctl      = (w_ctl_shr > 18'(Q16_ONE)) ? 17'(Q16_ONE) : w_ctl_shr[16:0];
  assign w_prod     = PROD_W'(w_ctl) * PROD_W'(FC_RANGE);
  assign w_off      = (SAMPLE_WIDTH+1)'(w_prod >> 16);
  assign w_sum      = (SAMPLE_WIDTH+2)'(w_off) + (SAMPLE_WIDTH+2)'(FC_MIN_DIGITAL);

  // The offset is non-negative, so only the ceiling can be exceeded.
  always_comb begin
    w_target = FC_MIN_DIGITAL;
    if (strength_q != 4'd0) begin
      if (w_sum > (SAMPLE_WIDTH+2)'(FC_MAX_DIGITAL)) begin
        w_target = FC_MAX_DIGITAL;
      end else begin
        w_target = w_sum[SAMPLE_WIDTH-1:0];
      end
    end
  end

  assign w_ch_ok = ((CH_W+1)'(ch_q) < (CH_W+1)'(NUM_CH));

`ifdef CUTOFF_SLEW_EN
  logic [SAMPLE_WIDTH-1:0] last_q [NUM_CH];
  logic [SAMPLE_WIDTH-1:0] w_last;
  logic [SAMPLE_WIDTH-1:0] w_slewed;

  always_comb begin
    w_last = FC_MIN_DIGITAL;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) w_last = last_q[i];
    end
  end

  // Move toward the target by at most SLEW_STEP from the channel's last value.
  always_comb begin
    w_slewed = w_target;
    if (w_target > w_last) begin
      if ((w_target - w_last) > SLEW_STEP) w_slewed = w_last + SLEW_STEP;
    end else begin
      if ((w_last - w_target) > SLEW_STEP) w_slewed = w_last - SLEW_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) last_q[i] <= FC_MIN_DIGITAL;
    end else if ((state_q == S_CALC) && w_ch_ok) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_q == CH_W'(i)) last_q[i] <= w_slewed;
      end
    end
  end

  assign w_freq = w_slewed;
`else
  logic [SAMPLE_WIDTH-1:0] w_unused_slew;
  assign w_unused_slew = SLEW_STEP;
  assign w_freq        = w_target;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q       <= '0;
      sat_q      <= 1'b0;
      strength_q <= '0;
      mode_q     <= MODE_LINEAR;
      mapped_q   <= '0;
      out_ch_q   <= '0;
      out_freq_q <= FC_MIN_DIGITAL;
    end else begin
      if (w_accept) begin
        ch_q       <= bus.in_ch;
        sat_q      <= (bus.env_avg >= C_TYP);
        strength_q <= bus.filter_strength_ratio;
        mode_q     <= mode_e'(bus.mode);
      end
      if (state_q == S_MAP) begin
        mapped_q <= w_mapped_d;
      end
      // Result registers load on entry to DONE and hold until the next one.
      if (state_q == S_CALC) begin
        out_ch_q   <= ch_q;
        out_freq_q <= w_ch_ok ? w_freq : FC_MIN_DIGITAL;
      end
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_ch    = out_ch_q;
  assign bus.out_freq  = out_freq_q;

endmodule
`default_nettype wire
